// File: rtl/lut_addsub_arb_i8.sv
`default_nettype none
// ============================================================================
// Module   : lut_addsub_arb_i8
// Purpose  : Round-robin arbiter and sequencer that shares one signed 8-bit
//            add/sub datapath among N requesters. One request is granted per
//            cycle. Its result is captured in a one-entry output register,
//            tagged with the requester index, and held until the consumer
//            accepts it.
// Ports    : clock, reset            - clock, synchronous active-high reset
//            req_valid/req_ready [N]  - per-requester handshake
//            req_a/req_b [8N]         - packed signed operands, lane i=[8i+:8]
//            req_op [N]               - 0 = a+b, 1 = a-b
//            rsp_valid/rsp_ready      - result handshake
//            rsp_y, rsp_id, rsp_ovf   - result, requester index, overflow
// Config   : `define LUT_ADDSUB_ARB_SAT_EN to saturate on signed overflow
//            (+ov -> 8'h7F, -ov -> 8'h80). rsp_ovf is reported either way.
// Revision : 1.0 - initial release
// ============================================================================
module lut_addsub_arb_i8 #(
    parameter int N   = 4,
    parameter int IDW = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [8*N-1:0]   req_a,
    input  logic [8*N-1:0]   req_b,
    input  logic [N-1:0]     req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_y,
    output logic [IDW-1:0]   rsp_id,
    output logic             rsp_ovf
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          r_state_q;
    logic [LW-1:0]   r_last_q;
    logic [7:0]      r_y_q;
    logic [IDW-1:0]  r_id_q;
    logic            r_ovf_q;

    logic            w_space;
    logic            w_found;
    logic            w_accept;
    logic [LW-1:0]   w_grant;
    logic [LW:0]     w_cand;

    logic [7:0]      w_a;
    logic [7:0]      w_b;
    logic [7:0]      w_b_eff;
    logic            w_sub;
    logic [7:0]      w_wrap;
    logic            w_ovf;
    logic [7:0]      w_y;

    // Rotating priority search: candidates last+1, last+2, ... wrapping at N.
    // One extra bit on w_cand keeps last+k from overflowing before the wrap.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = {1'b0, r_last_q} + (LW+1)'(k);
            if (w_cand >= (LW+1)'(N)) begin
                w_cand = w_cand - (LW+1)'(N);
            end
            if (!w_found && req_valid[w_cand[LW-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_cand[LW-1:0];
            end
        end
    end

    // The register can take a new result when empty or when it drains this cycle.
    assign w_space  = (r_state_q == S_EMPTY) | rsp_ready;
    // Reset gating keeps req_ready low during reset and blocks acceptance on the reset edge.
    assign w_accept = w_space & w_found & ~reset;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    // Shared datapath: subtraction as a + ~b + 1.
    assign w_a     = req_a[{w_grant, 3'b000} +: 8];
    assign w_b     = req_b[{w_grant, 3'b000} +: 8];
    assign w_sub   = req_op[w_grant];
    assign w_b_eff = w_sub ? ~w_b : w_b;
    assign w_wrap  = w_a + w_b_eff + {7'd0, w_sub};
    // Overflow iff the effective addends share a sign that the sum does not.
    assign w_ovf   = (w_a[7] == w_b_eff[7]) && (w_wrap[7] != w_a[7]);

`ifdef LUT_ADDSUB_ARB_SAT_EN
    // On overflow the true result has the sign of a.
    assign w_y = w_ovf ? (w_a[7] ? 8'h80 : 8'h7F) : w_wrap;
`else
    assign w_y = w_wrap;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= S_EMPTY;
            r_last_q  <= LW'(N - 1);
            r_y_q     <= 8'd0;
            r_id_q    <= '0;
            r_ovf_q   <= 1'b0;
        end else if (w_accept) begin
            // Covers both a plain load and a same-cycle drain-and-reload.
            r_state_q <= S_FULL;
            r_last_q  <= w_grant;
            r_y_q     <= w_y;
            r_id_q    <= IDW'(w_grant);
            r_ovf_q   <= w_ovf;
        end else if (rsp_ready) begin
            r_state_q <= S_EMPTY;
        end
    end

    assign rsp_valid = (r_state_q == S_FULL);
    assign rsp_y     = r_y_q;
    assign rsp_id    = r_id_q;
    assign rsp_ovf   = r_ovf_q;

endmodule
`default_nettype wire

// File: doc/lut_addsub_arb_i8.md
# lut_addsub_arb_i8

Round-robin arbiter and sequencer that shares one 8-bit LUT add/sub datapath among N requesters. Each requester presents a signed 8-bit operand pair and an opcode (add/sub) under a valid/ready handshake. The block grants one requester per cycle, computes the result, and holds it in a one-entry output register tagged with the requester ID until the consumer accepts it. It sits between compiler-generated LUT arithmetic clients and a shared `lut_add_i8_i8_i8`-class unit.

## Interface
- `N`, default 4: number of requesters. Legal range 2..8.
- `IDW`, default 3: width of `rsp_id`. Must be at least clog2(N).
- `clock`  in  1  sole clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clock`.
- `req_valid`  in  N  per-requester request valid.
- `req_ready`  out  N  per-requester accept strobe. At most one bit is high per cycle.
- `req_a`  in  8*N  operand a. Requester i uses bits [8i+7:8i], two's complement.
- `req_b`  in  8*N  operand b. Same packing as `req_a`.
- `req_op`  in  N  opcode. 0 = a+b, 1 = a−b.
- `rsp_valid`  out  1  result register holds a valid result.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_y`  out  8  result.
- `rsp_id`  out  IDW  index of the requester that produced `rsp_y`.
- `rsp_ovf`  out  1  signed overflow flag for `rsp_y`.

## Operation
- **Output buffer FSM** has two states.
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
  - Define `space` = EMPTY | (FULL & `rsp_ready`).
- **Grant.** When `space`=1 and any `req_valid` is set, the block grants the first valid requester found by searching from `last+1` upward, wrapping modulo N. It then drives `req_ready[g]`=1 combinationally. No other `req_ready` bit is high.
- **Acceptance.** A transfer on requester g occurs when `req_valid[g]` & `req_ready[g]`. On that edge:
  - The result register loads y, ovf, and id=g.
  - `last` ← g.
  - The FSM moves to or stays in FULL.
- **Drain.** If FULL & `rsp_ready` and there is no new grant in the same cycle, the FSM goes to EMPTY.
- **Simultaneous drain and accept.** The register is overwritten with the new result. The FSM stays FULL, which gives a throughput of one result per cycle.
- **Stall.** When FULL & !`rsp_ready`:
  - All `req_ready` are 0.
  - `rsp_y`, `rsp_id`, and `rsp_ovf` are held stable.
- **Arithmetic**, with a and b signed 8-bit:
  - y = (a ± b) mod 256.
  - ovf = 1 when the signed result falls outside −128..127. For add: the operands share a sign and the result sign differs. For sub: the operands differ in sign and the result sign differs from a.
- **Requester obligations.**
  - A requester keeps `req_valid` asserted until accepted.
  - Operands must not change while valid and unaccepted.
  - The arbiter does not require `req_ready` to be stable when `req_valid` is low.
- **Fairness.** Any continuously asserted requester is granted within N grants.

## Timing
- **Reset.**
  - While `reset` is high: `rsp_valid`=0, `rsp_y`=0, `rsp_id`=0, `rsp_ovf`=0, and all `req_ready`=0.
  - `last` ← N−1, so requester 0 has highest priority on the first grant after reset.
- **Reset mid-operation.** An in-flight result is discarded. A request presented on the reset edge is not accepted.
- **Latency.** A request accepted at edge k gives `rsp_valid`=1 with its result immediately after edge k (one-cycle latency).
- **Combinational paths.**
  - `req_ready` depends combinationally on `req_valid`, `rsp_ready`, and FSM state.
  - There is no combinational path from `req_a`, `req_b`, or `req_op` to any output.

## Configuration
- **Macro:** `LUT_ADDSUB_ARB_SAT_EN`.
- **Defined:** results saturate on overflow.
  - Positive overflow gives y = 8'h7F.
  - Negative overflow gives y = 8'h80.
  - `rsp_ovf` still reports the overflow.
- **Undefined:** y wraps modulo 256 and `rsp_ovf` reports the overflow.
- Latency, handshake, and arbitration behaviour are identical in both builds.

## Test plan
- **Reset values.** Hold `reset` for 16 cycles.
  - All outputs are 0 during reset.
  - Then present req0: a=1, b=−3, op=sub, with `rsp_ready`=1.
  - Required: one cycle later `rsp_valid`=1, `rsp_y`=8'd4, `rsp_id`=0, `rsp_ovf`=0.
- **Round-robin.** Assert all 4 `req_valid` continuously with `rsp_ready`=1.
  - Required: grants go 0,1,2,3,0 on consecutive cycles.
  - Required: `rsp_id` follows the same order one cycle later, with `rsp_valid` high throughout.
- **Backpressure.** Accept req2 (a=10, b=20, add), then hold `rsp_ready`=0 for 5 cycles.
  - Required: `rsp_y`=30 and `rsp_id`=2 are held for the full 5 cycles.
  - Required: all `req_ready`=0 during the stall.
  - Required: on release, the next grant occurs in the same cycle as the drain.
- **Overflow.** Run 100+100 (add) and −100−100 (sub: a=−100, b=100).
  - Without the macro: y=8'hC8, ovf=1 and y=8'h38, ovf=1.
  - With `LUT_ADDSUB_ARB_SAT_EN`: y=8'h7F and y=8'h80, with ovf=1 in both cases.
- **Reset mid-operation.** Assert `reset` while FULL with `rsp_ready`=0.
  - Required: next cycle `rsp_valid`=0.
  - Required: the first grant after reset goes to requester 0 even if requester 3 was last granted.
- **Fairness.** Hold req1 continuously while req0 toggles every cycle.
  - Required: req1 is granted at least once in every 2 grants.
